// File: rtl/nest_placer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nest_placer_pkg                                                            |
// | Shared nest-bank parameters, placer defaults and placer state encoding.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nest_placer_pkg;

    localparam int X_bits      = 10;
    localparam int Y_bits      = 9;
    localparam int NEST_RADIUS = 8;

    localparam int NUM_NESTS   = 4;
    localparam int X_MAX       = 639;
    localparam int Y_MAX       = 479;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOUNDS = 3'd1,
        ST_PROBE  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_REJECT = 3'd4
    } placer_state_t;

endpackage
`default_nettype wire

// File: rtl/nest_placer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nest_placer_if                                                             |
// | Request/response handshake between the setup UI and the nest placer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface nest_placer_if;
    import nest_placer_pkg::*;

    logic              place_req;
    logic [X_bits-1:0] req_x;
    logic [Y_bits-1:0] req_y;
    logic              place_ack;
    logic              place_rej;
    logic              busy;

    modport master (
        output place_req, req_x, req_y,
        input  place_ack, place_rej, busy
    );

    modport slave (
        input  place_req, req_x, req_y,
        output place_ack, place_rej, busy
    );

endinterface
`default_nettype wire

// File: rtl/nest_corner_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nest_corner_gen                                                            |
// | Selects probe corner k of a candidate footprint and flags out-of-bounds.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nest_corner_gen #(
    parameter int X_MAX = nest_placer_pkg::X_MAX,
    parameter int Y_MAX = nest_placer_pkg::Y_MAX
) (
    input  wire logic [nest_placer_pkg::X_bits-1:0] i_cx,
    input  wire logic [nest_placer_pkg::Y_bits-1:0] i_cy,
    input  wire logic [1:0]                         i_k,
    output logic      [nest_placer_pkg::X_bits-1:0] o_px,
    output logic      [nest_placer_pkg::Y_bits-1:0] o_py,
    output logic                                    o_oob
);
    import nest_placer_pkg::*;

    localparam logic [X_bits:0] c_radius_x = (X_bits+1)'(NEST_RADIUS);
    localparam logic [Y_bits:0] c_radius_y = (Y_bits+1)'(NEST_RADIUS);
    localparam logic [X_bits:0] c_x_max    = (X_bits+1)'(X_MAX);
    localparam logic [Y_bits:0] c_y_max    = (Y_bits+1)'(Y_MAX);

    logic [X_bits:0] w_x_lo;
    logic [X_bits:0] w_x_hi;
    logic [Y_bits:0] w_y_lo;
    logic [Y_bits:0] w_y_hi;

    // One extra bit: a set MSB on the low edge means the edge went negative.
    always_comb begin
        w_x_lo = {1'b0, i_cx} - c_radius_x;
        w_x_hi = {1'b0, i_cx} + c_radius_x;
        w_y_lo = {1'b0, i_cy} - c_radius_y;
        w_y_hi = {1'b0, i_cy} + c_radius_y;
    end

    always_comb begin
        o_oob = w_x_lo[X_bits] | (w_x_hi > c_x_max) |
                w_y_lo[Y_bits] | (w_y_hi > c_y_max);
        // k[0] picks the x edge, k[1] the y edge: 0=(lo,lo) 1=(hi,lo) 2=(lo,hi) 3=(hi,hi)
        o_px  = i_k[0] ? w_x_hi[X_bits-1:0] : w_x_lo[X_bits-1:0];
        o_py  = i_k[1] ? w_y_hi[Y_bits-1:0] : w_y_lo[Y_bits-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/nest_placer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nest_placer                                                                |
// | Setup-phase controller: bounds-checks, corner-probes and commits nests.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nest_placer #(
    parameter int NUM_NESTS = nest_placer_pkg::NUM_NESTS,
    parameter int X_MAX     = nest_placer_pkg::X_MAX,
    parameter int Y_MAX     = nest_placer_pkg::Y_MAX
) (
    input  wire logic                                    setup_clk,
    input  wire logic                                    RESET,
    input  wire logic                                    SETUP_PHASE,
    nest_placer_if.slave                                 req_if,
    output logic      [NUM_NESTS-1:0]                    nest_set,
    output logic      [nest_placer_pkg::X_bits-1:0]      nest_x,
    output logic      [nest_placer_pkg::Y_bits-1:0]      nest_y,
    output logic      [nest_placer_pkg::X_bits-1:0]      collide_x,
    output logic      [nest_placer_pkg::Y_bits-1:0]      collide_y,
    input  wire logic [NUM_NESTS-1:0]                    nest_collision,
    output logic      [NUM_NESTS-1:0]                    placed
);
    import nest_placer_pkg::*;

    localparam int c_count_w = $clog2(NUM_NESTS + 1);

    placer_state_t          r_state;
    placer_state_t          w_next_state;
    logic [1:0]             r_k;
    logic [c_count_w-1:0]   r_count;
    logic [NUM_NESTS-1:0]   r_placed;
    logic [X_bits-1:0]      r_x;
    logic [Y_bits-1:0]      r_y;

    logic [X_bits-1:0]      w_px;
    logic [Y_bits-1:0]      w_py;
    logic                   w_oob;
    logic                   w_accept;
    logic                   w_hit;
    logic                   w_ack;
    logic                   w_rej;
    logic                   w_busy;
    logic [NUM_NESTS-1:0]   w_nest_set;

    nest_corner_gen #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_corner (
        .i_cx  (r_x),
        .i_cy  (r_y),
        .i_k   (r_k),
        .o_px  (w_px),
        .o_py  (w_py),
        .o_oob (w_oob)
    );

    assign w_accept = (r_state == ST_IDLE) && SETUP_PHASE && req_if.place_req;
    // Slots that hold no nest yet may report anything; only committed slots count.
    assign w_hit    = |(nest_collision & r_placed);

    always_ff @(posedge setup_clk) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (&r_placed) ? ST_REJECT : ST_BOUNDS;
                end
            end
            ST_BOUNDS: begin
                if (!SETUP_PHASE) begin
                    w_next_state = ST_IDLE;
                end else if (w_oob) begin
                    w_next_state = ST_REJECT;
                end else begin
                    w_next_state = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (!SETUP_PHASE) begin
                    w_next_state = ST_IDLE;
                end else if (w_hit) begin
                    w_next_state = ST_REJECT;
                end else if (r_k == 2'd3) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            ST_REJECT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Losing the setup phase in the final cycle still suppresses the response.
    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_ack      = (r_state == ST_COMMIT) && SETUP_PHASE;
        w_rej      = (r_state == ST_REJECT) && SETUP_PHASE;
        w_nest_set = w_ack ? (NUM_NESTS'(1) << r_count) : '0;
        collide_x  = (r_state == ST_PROBE) ? w_px : r_x;
        collide_y  = (r_state == ST_PROBE) ? w_py : r_y;
    end

    always_ff @(posedge setup_clk) begin
        if (RESET) begin
            r_k      <= 2'd0;
            r_count  <= '0;
            r_placed <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            if (w_accept) begin
                r_x <= req_if.req_x;
                r_y <= req_if.req_y;
            end
            if (r_state == ST_BOUNDS) begin
                r_k <= 2'd0;
            end else if (r_state == ST_PROBE) begin
                r_k <= r_k + 2'd1;
            end
            if (w_ack) begin
                r_placed <= r_placed | w_nest_set;
                r_count  <= r_count + 1'b1;
            end
        end
    end

    assign req_if.place_ack = w_ack;
    assign req_if.place_rej = w_rej;
    assign req_if.busy      = w_busy;
    assign nest_set         = w_nest_set;
    assign nest_x           = r_x;
    assign nest_y           = r_y;
    assign placed           = r_placed;

endmodule
`default_nettype wire

// File: tb/tb_nest_placer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nest_placer                                                             |
// | Random and directed placement requests against a nest-bank reference model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nest_placer;
    import nest_placer_pkg::*;

    localparam int c_n    = 4;
    localparam int c_r    = NEST_RADIUS;
    localparam int c_xmax = 639;
    localparam int c_ymax = 479;

    typedef struct {
        bit ack;
        int lat;
        int slot;
        int issue;
    } exp_t;

    logic              clk;
    logic              RESET;
    logic              SETUP_PHASE;
    logic [c_n-1:0]    nest_set;
    logic [X_bits-1:0] nest_x;
    logic [Y_bits-1:0] nest_y;
    logic [X_bits-1:0] collide_x;
    logic [Y_bits-1:0] collide_y;
    logic [c_n-1:0]    nest_collision;
    logic [c_n-1:0]    placed;

    nest_placer_if bus ();

    nest_placer #(
        .NUM_NESTS (c_n),
        .X_MAX     (c_xmax),
        .Y_MAX     (c_ymax)
    ) dut (
        .setup_clk      (clk),
        .RESET          (RESET),
        .SETUP_PHASE    (SETUP_PHASE),
        .req_if         (bus),
        .nest_set       (nest_set),
        .nest_x         (nest_x),
        .nest_y         (nest_y),
        .collide_x      (collide_x),
        .collide_y      (collide_y),
        .nest_collision (nest_collision),
        .placed         (placed)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   mx[$];
    int   my[$];

    // Nest instances: load on SET, report whether the probe falls in their square.
    bit nv [c_n];
    int nx [c_n];
    int ny [c_n];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < c_n; i++) begin
            if (RESET) begin
                nv[i] <= 1'b0;
            end else if (nest_set[i]) begin
                nv[i] <= 1'b1;
                nx[i] <= int'(nest_x);
                ny[i] <= int'(nest_y);
            end
        end
    end

    // Empty slots deliberately report a collision so masking is exercised.
    always_comb begin
        for (int i = 0; i < c_n; i++) begin
            nest_collision[i] = 1'b1;
            if (nv[i]) begin
                nest_collision[i] = (int'(collide_x) >= nx[i] - c_r) && (int'(collide_x) <= nx[i] + c_r) &&
                                    (int'(collide_y) >= ny[i] - c_r) && (int'(collide_y) <= ny[i] + c_r);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_mask();
        return (1 << mx.size()) - 1;
    endfunction

    // Reference verdict and latency from the placement rules.
    function automatic void model(input int x, input int y, output bit ack, output int lat);
        int qx[4];
        int qy[4];
        ack = 1'b0;
        if (mx.size() == c_n) begin
            lat = 1;
            return;
        end
        if (x - c_r < 0 || x + c_r > c_xmax || y - c_r < 0 || y + c_r > c_ymax) begin
            lat = 2;
            return;
        end
        qx = '{x - c_r, x + c_r, x - c_r, x + c_r};
        qy = '{y - c_r, y - c_r, y + c_r, y + c_r};
        for (int k = 0; k < 4; k++) begin
            foreach (mx[j]) begin
                if (iabs(qx[k] - mx[j]) <= c_r && iabs(qy[k] - my[j]) <= c_r) begin
                    lat = 3 + k;
                    return;
                end
            end
        end
        ack = 1'b1;
        lat = 6;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!RESET) begin
            if (nest_set != '0 && !bus.place_ack) begin
                chk("set_without_ack", int'(nest_set), 0);
            end
            if (bus.place_ack || bus.place_rej) begin
                if (sb.size() == 0) begin
                    chk("unexpected_response", int'({bus.place_ack, bus.place_rej}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_ack", int'(bus.place_ack), int'(e.ack));
                    chk("resp_rej", int'(bus.place_rej), int'(!e.ack));
                    chk("resp_latency", cyc - e.issue, e.lat);
                    chk("resp_nest_set", int'(nest_set), e.ack ? (1 << e.slot) : 0);
                end
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_ack", int'(bus.place_ack), 0);
        chk("rst_rej", int'(bus.place_rej), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_nest_set", int'(nest_set), 0);
        chk("rst_placed", int'(placed), 0);
        chk("rst_nest_x", int'(nest_x), 0);
        chk("rst_nest_y", int'(nest_y), 0);
        chk("rst_collide_x", int'(collide_x), 0);
        chk("rst_collide_y", int'(collide_y), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        bus.place_req = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        RESET = 1'b0;
        mx.delete();
        my.delete();
    endtask

    task automatic do_req(input int x, input int y);
        exp_t e;
        bit   a;
        int   l;
        int   t;
        model(x, y, a, l);
        @(negedge clk);
        e.ack   = a;
        e.lat   = l;
        e.slot  = mx.size();
        e.issue = cyc;
        sb.push_back(e);
        bus.place_req = 1'b1;
        bus.req_x     = X_bits'(x);
        bus.req_y     = Y_bits'(y);
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (!a && l == 2 && bus.busy) begin
                chk("oob_collide_x", int'(collide_x), x);
                chk("oob_collide_y", int'(collide_y), y);
            end
        end while (!(bus.place_ack || bus.place_rej) && t < 20);
        bus.place_req = 1'b0;
        if (!(bus.place_ack || bus.place_rej)) begin
            chk("response_timeout", t, l);
        end
        if (a) begin
            mx.push_back(x);
            my.push_back(y);
        end
        @(negedge clk);
        chk("placed_mask", int'(placed), model_mask());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x;
        int y;
        int j;
        RESET         = 1'b1;
        SETUP_PHASE   = 1'b1;
        bus.place_req = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        RESET = 1'b0;

        do_req(100, 100);
        do_req(110, 105);
        do_req(5, 200);
        do_req(631, 471);
        do_req(632, 471);
        do_req(633, 100);

        do_reset();
        do_req(50, 50);
        do_req(150, 50);
        do_req(250, 50);
        do_req(350, 50);
        do_req(450, 50);

        // Setup phase lost while probing corner 2: no response, nothing committed.
        do_reset();
        do_req(100, 100);
        @(negedge clk);
        bus.place_req = 1'b1;
        bus.req_x     = X_bits'(300);
        bus.req_y     = Y_bits'(300);
        repeat (4) @(negedge clk);
        chk("probe2_busy", int'(bus.busy), 1);
        chk("probe2_collide_x", int'(collide_x), 300 - c_r);
        chk("probe2_collide_y", int'(collide_y), 300 + c_r);
        SETUP_PHASE   = 1'b0;
        bus.place_req = 1'b0;
        @(negedge clk);
        chk("setup_drop_busy", int'(bus.busy), 0);
        chk("setup_drop_ack", int'(bus.place_ack), 0);
        chk("setup_drop_rej", int'(bus.place_rej), 0);
        repeat (3) @(negedge clk);
        chk("setup_drop_placed", int'(placed), model_mask());
        SETUP_PHASE = 1'b1;

        // Reset in the middle of probing.
        @(negedge clk);
        bus.place_req = 1'b1;
        bus.req_x     = X_bits'(400);
        bus.req_y     = Y_bits'(300);
        repeat (3) @(negedge clk);
        RESET         = 1'b1;
        bus.place_req = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        RESET = 1'b0;
        mx.delete();
        my.delete();

        for (int n = 0; n < 70; n++) begin
            if (mx.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, mx.size() - 1));
                x = mx[j] + int'($urandom_range(0, 40)) - 20;
                y = my[j] + int'($urandom_range(0, 40)) - 20;
            end else begin
                x = int'($urandom_range(0, 660));
                y = int'($urandom_range(0, 500));
            end
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            do_req(x, y);
            if (mx.size() == c_n && $urandom_range(0, 2) == 0) begin
                do_reset();
            end
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
